sqrt_request_arbiter: RTL
=========================

# sqrt_request_arbiter

Shares one `CordicSquareRoot` unit between `N_REQ` clocked requesters. Round-robin selects one pending operand, launches the unit by holding then releasing its reset, and waits for `finished`. It then returns the result, tagged with the requester ID, on a single response channel. It sits between the core-side request ports and the square-root unit, and is the only driver of the unit's `data_i` and `arst`.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `FP32`, `pa_AsyncCordic::FP32`: MSB index of operand and result words.
- `TIMEOUT_CYCLES`, 1023: watchdog limit in RUN; used only when `SQRT_ARB_TIMEOUT_EN` is defined.
- `ck` in 1: single clock.
- `arst` in 1: reset, asynchronous, active-high.
- `req_valid_i` in N_REQ: per-requester operand valid.
- `req_data_i` in N_REQ×(FP32+1): per-requester operand.
- `req_ready_o` out N_REQ: one-hot accept strobe.
- `sqrt_data_o` out FP32+1: operand to the unit's `data_i`.
- `sqrt_arst_o` out 1: reset to the unit's `arst`.
- `sqrt_finished_i` in 1: unit `finished`; treated as asynchronous.
- `sqrt_result_i` in FP32+1: unit `data_o`.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response accept.
- `rsp_id_o` out $clog2(N_REQ): index of the served requester.
- `rsp_data_o` out FP32+1: result.
- `rsp_timeout_o` out 1: result invalid, watchdog expired.

## Operation
- FSM states are IDLE, LAUNCH, RUN and RESP.
- **IDLE**
  - `req_ready_o` is combinational: the one-hot round-robin grant over `req_valid_i`, starting at `(last_id+1) mod N_REQ`. It is all-zero if no request is valid.
  - On handshake, the operand is registered into `sqrt_data_o` and the index into `rsp_id_o` and `last_id`. The FSM then goes to LAUNCH.
- **LAUNCH**: lasts exactly 1 cycle. `sqrt_arst_o` stays 1 with the operand now stable. The finished synchronizer is cleared. The FSM goes to RUN.
- **RUN**
  - `sqrt_arst_o`=0.
  - `sqrt_finished_i` passes through a 2-flop synchronizer.
  - On the first cycle the synchronized finished is 1: capture `sqrt_result_i` into `rsp_data_o`, set `rsp_timeout_o`=0, and go to RESP.
- **RESP**
  - `rsp_valid_o`=1. All response outputs are held stable until `rsp_ready_i`.
  - On handshake, go to IDLE.
  - `sqrt_arst_o`=1 again.
- `sqrt_arst_o`=1 in every state except RUN, so the unit idles in reset.
- `req_ready_o` is all-zero outside IDLE. Requests wait; there is no queueing.
- Grant is fair: with every requester permanently valid, grants cycle 0,1,…,N_REQ-1,0.
- `sqrt_data_o` and `rsp_*` change only at the state transitions listed above.

## Timing
- **Reset values**
  - State = IDLE, `last_id`=N_REQ-1 (so requester 0 has first priority).
  - `sqrt_arst_o`=1, `sqrt_data_o`=0.
  - `req_ready_o`=0 (combinational from `valid` in IDLE).
  - `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_data_o`=0, `rsp_timeout_o`=0.
  - Synchronizer flops = 0.
- **Cycle-level sequence**
  - Accept at edge T. LAUNCH spans T→T+1. RUN begins at T+1, where `sqrt_arst_o` falls.
  - Raw `finished` rising before edge F gives RESP at F+2. `rsp_valid_o` is high from F+2.
  - RESP handshake at edge R gives IDLE at R. The next accept is earliest at edge R+1.
- **Minimum occupancy**: 4 cycles plus the unit's compute time.
- **Reset mid-operation**: `arst` at any point returns the block to IDLE and drives `sqrt_arst_o`=1 asynchronously. Any in-flight request is dropped and no response is produced.
- **Simultaneous events**: a request arriving in the same cycle as a RESP handshake is not accepted until the next IDLE cycle.

## Configuration
- Macro: `SQRT_ARB_TIMEOUT_EN`.
- **Defined**
  - A counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches `TIMEOUT_CYCLES` with synchronized finished still 0, the FSM goes to RESP with `rsp_timeout_o`=1 and `rsp_data_o`=0.
  - If finished and timeout occur in the same cycle, finished wins.
- **Undefined**
  - There is no counter and RUN waits indefinitely.
  - `rsp_timeout_o` is kept as a port and tied to 0.

## Structure
- The following belong in `pa_AsyncCordic`:
  - the state enum `sqrt_arb_state_t`;
  - the synchronizer depth constant `SQRT_SYNC_STAGES`=2;
  - the default-timeout constant.
- Sub-module `rr_arbiter`: parameterised by N, with inputs `req` and `last_id` and output one-hot `grant`. It is purely combinational, using a double-width rotate-mask.
- The FSM, synchronizer and registers stay in `sqrt_request_arbiter`.

## Test plan
- **Single request**: req0 with 0x40800000 (4.0), unit model finishes after 20 cycles → `rsp_id_o`=0, `rsp_data_o`=0x40000000, `sqrt_arst_o` low exactly during RUN.
- **All four valid from reset**: operands 1.0, 4.0, 9.0, 16.0 → responses in ID order 0,1,2,3 with 0x3F800000, 0x40000000, 0x40400000, 0x40800000.
- **Backpressure**: `rsp_ready_i`=0 for 10 cycles in RESP → outputs stable, `req_ready_o`=0, no new launch.
- **`arst` asserted mid-RUN**: → `sqrt_arst_o`=1 immediately, `rsp_valid_o` never rises, the next request is served normally after reset.
- **Timeout (`SQRT_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8)**: unit never finishes → `rsp_valid_o` with `rsp_timeout_o`=1, `rsp_data_o`=0 at RUN entry + 8 cycles.
- **Stale finished**: unit model holds `finished`=1 into the next LAUNCH → the next result is not captured before its own finished edge.

Source files
------------

// File: rtl/sqrt_request_arbiter_pkg.sv
// Shared types and constants for the square-root request arbiter.
// Package name is fixed by the CORDIC unit codebase it plugs into.
package pa_AsyncCordic;

  localparam int FP32                 = 31;
  localparam int SQRT_SYNC_STAGES     = 2;
  localparam int SQRT_TIMEOUT_DEFAULT = 1023;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    RESP   = 2'd3
  } sqrt_arb_state_t;

endpackage

// File: rtl/sqrt_request_arbiter_if.sv
// Request, square-root unit and response signals of the arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface sqrt_request_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int FP32  = pa_AsyncCordic::FP32
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid_i;
  logic [N_REQ-1:0][FP32:0] req_data_i;
  logic [N_REQ-1:0]         req_ready_o;
  logic [FP32:0]            sqrt_data_o;
  logic                     sqrt_arst_o;
  logic                     sqrt_finished_i;
  logic [FP32:0]            sqrt_result_i;
  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [ID_W-1:0]          rsp_id_o;
  logic [FP32:0]            rsp_data_o;
  logic                     rsp_timeout_o;

  modport slave (
    input  req_valid_i, req_data_i, sqrt_finished_i, sqrt_result_i, rsp_ready_i,
    output req_ready_o, sqrt_data_o, sqrt_arst_o, rsp_valid_o, rsp_id_o,
           rsp_data_o, rsp_timeout_o
  );

  modport master (
    output req_valid_i, req_data_i, sqrt_finished_i, sqrt_result_i, rsp_ready_i,
    input  req_ready_o, sqrt_data_o, sqrt_arst_o, rsp_valid_o, rsp_id_o,
           rsp_data_o, rsp_timeout_o
  );

endinterface

// File: rtl/sqrt_request_arbiter_rr_arbiter.sv
// Combinational round-robin grant: lowest valid index at or after last_id+1,
// found by rotating the request vector through a double-width copy.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_id,
  output logic [N-1:0]         grant
);
  localparam int IDW = $clog2(N);

  logic [IDW-1:0] start;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_g;
  logic [2*N-1:0] back;

  assign start = (last_id == IDW'(N - 1)) ? '0 : last_id + IDW'(1);
  assign dbl   = {req, req};
  assign rot   = N'(dbl >> start);
  // isolate lowest set bit, i.e. first requester from the start position
  assign rot_g = rot & (~rot + N'(1));
  assign back  = {rot_g, rot_g} << start;
  assign grant = N'(back >> N);

endmodule

// File: rtl/sqrt_request_arbiter.sv
// Shares one CORDIC square-root unit between N_REQ requesters, round-robin.
// Optional watchdog in RUN enabled by macro SQRT_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | unit held in reset, grant offered to pending requesters
// LAUNCH | operand registered, unit still in reset for one cycle
// RUN    | unit released, waiting for synchronized finished
// RESP   | response held on the output until accepted
module sqrt_request_arbiter
  import pa_AsyncCordic::*;
#(
  parameter int N_REQ          = 4,
  parameter int FP32           = pa_AsyncCordic::FP32,
  parameter int TIMEOUT_CYCLES = SQRT_TIMEOUT_DEFAULT
) (
  input logic                  ck,
  input logic                  arst,
  sqrt_request_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  sqrt_arb_state_t             state_q, state_d;
  logic [ID_W-1:0]             last_id_q;
  logic [ID_W-1:0]             grant_id;
  logic [N_REQ-1:0]            grant;
  logic [N_REQ-1:0]            req_ready;
  logic                        rsp_valid;
  logic                        accept;
  logic                        fin_sync;
  logic                        tmo_hit;
  logic [SQRT_SYNC_STAGES-1:0] fin_sync_q;
  logic [FP32:0]               data_q;
  logic [FP32:0]               rsp_data_q;
  logic [ID_W-1:0]             rsp_id_q;
  logic                        sqrt_arst_q;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req    (bus.req_valid_i),
    .last_id(last_id_q),
    .grant  (grant)
  );

  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  assign accept   = (state_q == IDLE) && (|bus.req_valid_i);
  assign fin_sync = fin_sync_q[SQRT_SYNC_STAGES-1];

  // synchronizer only samples in RUN, so a finished left over from the
  // previous operation never survives LAUNCH
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      fin_sync_q <= '0;
    end else if (state_q == RUN) begin
      fin_sync_q <= {fin_sync_q[SQRT_SYNC_STAGES-2:0], bus.sqrt_finished_i};
    end else begin
      fin_sync_q <= '0;
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             rsp_timeout_q;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      tmo_cnt_q <= '0;
    end else if (state_q == LAUNCH) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RUN) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // counter holds the number of completed RUN cycles, so this is the last one
  assign tmo_hit = (state_q == RUN) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      rsp_timeout_q <= 1'b0;
    end else if (state_q == RUN && state_d == RESP) begin
      rsp_timeout_q <= ~fin_sync;
    end
  end

  assign bus.rsp_timeout_o = rsp_timeout_q;
`else
  assign tmo_hit           = 1'b0;
  assign bus.rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge ck or posedge arst) begin
    if (arst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LAUNCH;
      LAUNCH:  state_d = RUN;
      RUN:     if (fin_sync || tmo_hit) state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = grant;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // unit reset is registered from the next state so it never glitches
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      last_id_q   <= ID_W'(N_REQ - 1);
      data_q      <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      sqrt_arst_q <= 1'b1;
    end else begin
      sqrt_arst_q <= (state_d != RUN);
      if (accept) begin
        data_q    <= bus.req_data_i[grant_id];
        rsp_id_q  <= grant_id;
        last_id_q <= grant_id;
      end
      if (state_q == RUN && state_d == RESP) begin
        rsp_data_q <= fin_sync ? bus.sqrt_result_i : '0;
      end
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.sqrt_data_o = data_q;
  assign bus.sqrt_arst_o = sqrt_arst_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_data_o  = rsp_data_q;

endmodule
